// File: rtl/sha_sched_pkg.sv
// Shared types and default sizing for the SHA batch scheduler.
package sha_sched_pkg;

    localparam int DEF_NUM_CORES = 10;
    localparam int DEF_IDX_W     = 4;
    localparam int DEF_NONCE_W   = 32;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        SCAN,
        ADVANCE
    } sched_state_t;

endpackage

// File: rtl/sha_batch_scheduler_launch_shifter.sv
// One-hot launch strobe: load puts a 1 in bit 0, shift walks it up one bit per cycle.
module launch_shifter #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             clear,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            q <= '0;
        end else if (load) begin
            q <= WIDTH'(1);
        end else if (shift) begin
            q <= {q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/sha_batch_scheduler.sv
// Batch sequencer for a bank of SHA cores: staggered launch, completion wait,
// serial target scan of the captured hashes, and advance to the next nonce batch.
module sha_batch_scheduler
    import sha_sched_pkg::*;
#(
    parameter int                 NUM_CORES   = DEF_NUM_CORES,
    parameter int                 IDX_W       = DEF_IDX_W,
    parameter int                 NONCE_W     = DEF_NONCE_W,
    parameter logic [NONCE_W-1:0] NONCE_START = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic [NUM_CORES-1:0] core_begin,
    input  logic [NUM_CORES-1:0] core_done,
    output logic [NONCE_W-1:0]   nonce_base,
    output logic                 hash_capture,
    output logic [IDX_W-1:0]     cmp_sel,
    input  logic                 cmp_lt,
    output logic                 busy,
    output logic                 done,
    output logic                 found,
    output logic [NONCE_W-1:0]   found_nonce
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CORES - 1);
    // Offset from the current base to the last nonce of the following batch.
    localparam logic [NONCE_W:0] NEXT_END_OFS = (NONCE_W + 1)'(2 * NUM_CORES - 1);

    sched_state_t         state, state_nx;
    logic [IDX_W-1:0]     idx_nx;
    logic [NUM_CORES-1:0] done_mask, mask_nx;
    logic [NONCE_W-1:0]   base_nx, fnonce_nx;
    logic                 done_nx, found_nx, cap_nx;
    logic                 sh_load, sh_shift, sh_clear;
    logic [NONCE_W:0]     next_end;

    assign next_end = {1'b0, nonce_base} + NEXT_END_OFS;

    launch_shifter #(.WIDTH(NUM_CORES)) u_launch (
        .clk   (clk),
        .rst   (rst),
        .load  (sh_load),
        .shift (sh_shift),
        .clear (sh_clear),
        .q     (core_begin)
    );

    always_comb begin
        state_nx  = state;
        idx_nx    = cmp_sel;
        mask_nx   = done_mask;
        base_nx   = nonce_base;
        done_nx   = done;
        found_nx  = found;
        fnonce_nx = found_nonce;
        cap_nx    = 1'b0;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;
        sh_clear  = 1'b0;
        if (abort && state != IDLE) begin
            state_nx = IDLE;
            sh_clear = 1'b1;
            mask_nx  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state_nx  = LAUNCH;
                        sh_load   = 1'b1;
                        idx_nx    = '0;
                        mask_nx   = '0;
                        base_nx   = NONCE_START;
                        done_nx   = 1'b0;
                        found_nx  = 1'b0;
                        fnonce_nx = '0;
                    end
                end
                LAUNCH: begin
                    mask_nx = done_mask | core_done;
                    if (cmp_sel == LAST_IDX) begin
                        state_nx = WAIT;
                        sh_clear = 1'b1;
                    end else begin
                        sh_shift = 1'b1;
                        idx_nx   = cmp_sel + 1'b1;
                    end
                end
                WAIT: begin
                    mask_nx = done_mask | core_done;
                    if (&done_mask) begin
                        state_nx = SCAN;
                        cap_nx   = 1'b1;
                        idx_nx   = '0;
                    end
                end
                SCAN: begin
                    if (cmp_lt) begin
                        state_nx  = IDLE;
                        fnonce_nx = nonce_base + NONCE_W'(cmp_sel);
                        found_nx  = 1'b1;
                        done_nx   = 1'b1;
                    end else if (cmp_sel == LAST_IDX) begin
                        state_nx = ADVANCE;
                    end else begin
                        idx_nx = cmp_sel + 1'b1;
                    end
                end
                ADVANCE: begin
                    // Only full batches are dispatched; a batch that would cross the top of the nonce space ends the job.
                    if (next_end[NONCE_W]) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                        found_nx = 1'b0;
                    end else begin
                        state_nx = LAUNCH;
                        base_nx  = nonce_base + NONCE_W'(NUM_CORES);
                        sh_load  = 1'b1;
                        idx_nx   = '0;
                        mask_nx  = '0;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cmp_sel      <= '0;
            done_mask    <= '0;
            nonce_base   <= NONCE_START;
            hash_capture <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            found        <= 1'b0;
            found_nonce  <= '0;
        end else begin
            state        <= state_nx;
            cmp_sel      <= idx_nx;
            done_mask    <= mask_nx;
            nonce_base   <= base_nx;
            hash_capture <= cap_nx;
            busy         <= (state_nx != IDLE);
            done         <= done_nx;
            found        <= found_nx;
            found_nonce  <= fnonce_nx;
        end
    end

endmodule

// File: tb/tb_sha_batch_scheduler.sv
// Self-checking bench: two scheduler instances (low and near-top nonce start) driven by a core/comparator model.
module tb_sha_batch_scheduler;

    localparam int          N        = 10;
    localparam logic [31:0] HI_START = 32'hFFFF_FFEC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_lo = 1'b0, start_hi = 1'b0, abort_lo = 1'b0, abort_hi = 1'b0;
    logic [N-1:0] core_done = '0;

    logic [N-1:0] cb_lo, cb_hi;
    logic [31:0]  nb_lo, nb_hi, fn_lo, fn_hi;
    logic         cap_lo, cap_hi, lt_lo, lt_hi;
    logic [3:0]   sel_lo, sel_hi;
    logic         busy_lo, busy_hi, done_lo, done_hi, found_lo, found_hi;

    always #5 clk = ~clk;

    sha_batch_scheduler #(.NUM_CORES(N), .IDX_W(4), .NONCE_W(32), .NONCE_START(32'd0)) dut (
        .clk(clk), .rst(rst), .start(start_lo), .abort(abort_lo),
        .core_begin(cb_lo), .core_done(core_done), .nonce_base(nb_lo),
        .hash_capture(cap_lo), .cmp_sel(sel_lo), .cmp_lt(lt_lo),
        .busy(busy_lo), .done(done_lo), .found(found_lo), .found_nonce(fn_lo));

    sha_batch_scheduler #(.NUM_CORES(N), .IDX_W(4), .NONCE_W(32), .NONCE_START(HI_START)) dut_hi (
        .clk(clk), .rst(rst), .start(start_hi), .abort(abort_hi),
        .core_begin(cb_hi), .core_done(core_done), .nonce_base(nb_hi),
        .hash_capture(cap_hi), .cmp_sel(sel_hi), .cmp_lt(lt_hi),
        .busy(busy_hi), .done(done_hi), .found(found_hi), .found_nonce(fn_hi));

    // Comparator model: a nonce "hashes below target" when it is in the winning set.
    logic [31:0] win [4];
    int          win_n = 0;
    logic [31:0] cand_lo, cand_hi;
    assign cand_lo = nb_lo + {28'd0, sel_lo};
    assign cand_hi = nb_hi + {28'd0, sel_hi};
    assign lt_lo = (win_n > 0 && cand_lo == win[0]) || (win_n > 1 && cand_lo == win[1]) ||
                   (win_n > 2 && cand_lo == win[2]) || (win_n > 3 && cand_lo == win[3]);
    assign lt_hi = (win_n > 0 && cand_hi == win[0]) || (win_n > 1 && cand_hi == win[1]) ||
                   (win_n > 2 && cand_hi == win[2]) || (win_n > 3 && cand_hi == win[3]);

    logic use_hi = 1'b0;
    logic [N-1:0] ob_cb;
    logic [31:0]  ob_nb, ob_fn;
    logic         ob_cap, ob_busy, ob_done, ob_found;
    assign ob_cb    = use_hi ? cb_hi    : cb_lo;
    assign ob_nb    = use_hi ? nb_hi    : nb_lo;
    assign ob_fn    = use_hi ? fn_hi    : fn_lo;
    assign ob_cap   = use_hi ? cap_hi   : cap_lo;
    assign ob_busy  = use_hi ? busy_hi  : busy_lo;
    assign ob_done  = use_hi ? done_hi  : done_lo;
    assign ob_found = use_hi ? found_hi : found_lo;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: walk full batches from the start nonce; the first batch holding a
    // winner reports its lowest winning nonce; stop when the next batch would not fit.
    task automatic model(input logic [31:0] s, output bit f, output logic [31:0] fn, output int nb);
        longint base;
        logic [31:0] n;
        base = longint'(s);
        f = 1'b0; fn = '0; nb = 0;
        for (int b = 0; b < 100 && !f; b++) begin
            nb++;
            for (int i = 0; i < N && !f; i++) begin
                n = 32'(base + i);
                for (int j = 0; j < win_n; j++)
                    if (win[j] == n) begin f = 1'b1; fn = n; end
            end
            if (!f) begin
                if (base + 2 * N - 1 > 64'hFFFF_FFFF) break;
                base += N;
            end
        end
    endtask

    task automatic run_job(input bit hi, input bit poke, input bit ef, input logic [31:0] en,
                           input int eb, input logic [31:0] s);
        int dly [N];
        bit pend [N];
        int launches, caps, last, k;
        bit fin, poked;
        launches = 0; caps = 0; last = -1; fin = 1'b0; poked = 1'b0;
        for (int i = 0; i < N; i++) begin pend[i] = 1'b0; dly[i] = 0; end
        use_hi = hi;
        @(negedge clk);
        if (hi) start_hi = 1'b1; else start_lo = 1'b1;
        @(negedge clk);
        chk("busy_after_start", 64'(ob_busy), 64'd1);
        chk("done_cleared_on_start", 64'(ob_done), 64'd0);
        for (int c = 1; c <= 3000 && !fin; c++) begin
            start_lo = 1'b0; start_hi = 1'b0;
            core_done = '0;
            if (ob_cb != '0) begin
                k = launches % N;
                chk("launch_onehot", 64'(ob_cb), 64'd1 << k);
                if (launches == 0) chk("first_launch_cycle", 64'(c), 64'd1);
                else if (k != 0) chk("launch_consecutive", 64'(c), 64'(last + 1));
                last = c;
                pend[k] = 1'b1;
                dly[k] = int'($urandom_range(0, 5));
                launches++;
            end
            if (ob_cap) begin
                caps++;
                if (poke && !poked) begin
                    poked = 1'b1;
                    if (hi) start_hi = 1'b1; else start_lo = 1'b1;
                end
            end
            for (int i = 0; i < N; i++)
                if (pend[i]) begin
                    if (dly[i] == 0) begin core_done[i] = 1'b1; pend[i] = 1'b0; end
                    else dly[i]--;
                end
            if (ob_done) fin = 1'b1;
            else @(negedge clk);
        end
        start_lo = 1'b0; start_hi = 1'b0; core_done = '0;
        chk("job_finished", 64'(fin), 64'd1);
        chk("found", 64'(ob_found), 64'(ef));
        chk("found_nonce", 64'(ob_fn), ef ? 64'(en) : 64'd0);
        chk("busy_at_done", 64'(ob_busy), 64'd0);
        chk("capture_count", 64'(caps), 64'(eb));
        chk("launch_count", 64'(launches), 64'(eb * N));
        chk("final_nonce_base", 64'(ob_nb), 64'(s + 32'(N * (eb - 1))));
        @(negedge clk);
        chk("done_held", 64'(ob_done), 64'd1);
    endtask

    typedef struct {
        bit hi; int w0; int w1; bit poke; bit ef; int eoff; int eb;
    } vec_t;

    task automatic set_wins(input logic [31:0] s, input int w0, input int w1);
        win_n = 0;
        if (w0 >= 0) begin win[win_n] = s + 32'(w0); win_n++; end
        if (w1 >= 0) begin win[win_n] = s + 32'(w1); win_n++; end
    endtask

    initial begin
        vec_t vecs [10];
        logic [31:0] s, mfn;
        bit mf;
        int mnb, w0, w1, guard;

        vecs[0] = '{0,  3, -1, 0, 1,  3, 1};
        vecs[1] = '{0, 17, -1, 0, 1, 17, 2};
        vecs[2] = '{0,  5,  2, 1, 1,  2, 1};
        vecs[3] = '{0, 29, 12, 0, 1, 12, 2};
        vecs[4] = '{0,  9, 10, 0, 1,  9, 1};
        vecs[5] = '{0, 10,  0, 0, 1,  0, 1};
        vecs[6] = '{1, -1, -1, 0, 0,  0, 2};
        vecs[7] = '{1, 19, -1, 0, 1, 19, 2};
        vecs[8] = '{1, 20, -1, 0, 0,  0, 2};
        vecs[9] = '{0, 25, -1, 1, 1, 25, 3};

        @(negedge clk);
        @(negedge clk);
        chk("rst_core_begin", 64'(cb_lo), 64'd0);
        chk("rst_hash_capture", 64'(cap_lo), 64'd0);
        chk("rst_cmp_sel", 64'(sel_lo), 64'd0);
        chk("rst_busy", 64'(busy_lo), 64'd0);
        chk("rst_done", 64'(done_lo), 64'd0);
        chk("rst_found", 64'(found_lo), 64'd0);
        chk("rst_found_nonce", 64'(fn_lo), 64'd0);
        chk("rst_nonce_base", 64'(nb_lo), 64'd0);
        chk("rst_nonce_base_hi", 64'(nb_hi), 64'(HI_START));
        rst = 1'b0;

        for (int v = 0; v < 10; v++) begin
            s = vecs[v].hi ? HI_START : 32'd0;
            set_wins(s, vecs[v].w0, vecs[v].w1);
            run_job(vecs[v].hi, vecs[v].poke, vecs[v].ef, s + 32'(vecs[v].eoff), vecs[v].eb, s);
        end

        // Abort after core 4 is launched, then a clean restart.
        use_hi = 1'b0;
        set_wins(32'd0, 3, -1);
        @(negedge clk); start_lo = 1'b1;
        @(negedge clk); start_lo = 1'b0;
        guard = 0;
        while (cb_lo != 10'h010 && guard < 20) begin @(negedge clk); guard++; end
        chk("abort_reached_core4", 64'(cb_lo), 64'h010);
        abort_lo = 1'b1;
        @(negedge clk); abort_lo = 1'b0;
        chk("abort_core_begin", 64'(cb_lo), 64'd0);
        chk("abort_busy", 64'(busy_lo), 64'd0);
        chk("abort_done", 64'(done_lo), 64'd0);
        chk("abort_found", 64'(found_lo), 64'd0);
        @(negedge clk);
        chk("abort_stays_idle", 64'(busy_lo), 64'd0);
        run_job(1'b0, 1'b0, 1'b1, 32'd3, 1, 32'd0);

        // start and abort together from IDLE: abort wins.
        @(negedge clk); start_lo = 1'b1; abort_lo = 1'b1;
        @(negedge clk); start_lo = 1'b0; abort_lo = 1'b0;
        chk("start_abort_busy", 64'(busy_lo), 64'd0);
        chk("start_abort_core_begin", 64'(cb_lo), 64'd0);
        @(negedge clk);
        chk("start_abort_still_idle", 64'(cb_lo), 64'd0);

        // Randomized jobs against the reference model.
        for (int r = 0; r < 8; r++) begin
            s  = (r < 5) ? 32'd0 : HI_START;
            w0 = int'($urandom_range(0, (r < 5) ? 39 : 25));
            w1 = int'($urandom_range(0, (r < 5) ? 39 : 25));
            set_wins(s, w0, w1);
            model(s, mf, mfn, mnb);
            run_job(r >= 5, r[0], mf, mfn, mnb, s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
